// File: rtl/writeback_unit.sv
// Write-back unit: a pending-write FIFO in front of a 32-entry register file.
// Read ports forward from the youngest queued write before falling back to the registers.
module writeback_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wb_valid,
  output logic                      wb_ready,
  input  logic [4:0]                wb_rd,
  input  logic [XLEN-1:0]           wb_data,
  input  logic                      commit_en,
  input  logic [4:0]                rs1_addr,
  input  logic [4:0]                rs2_addr,
  output logic [XLEN-1:0]           rs1_data,
  output logic [XLEN-1:0]           rs2_data,
  output logic                      commit_valid,
  output logic [4:0]                commit_rd,
  output logic [$clog2(DEPTH):0]    queue_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned NREG = 32;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } entry_t;

  logic [XLEN-1:0] regfile   [NREG];
  entry_t          queue_mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;
  entry_t          head_entry;

  // Ready depends only on registered occupancy, so a same-edge pop never frees a slot early.
  assign wb_ready    = (count != CW'(DEPTH));
  assign push        = wb_valid && wb_ready;
  assign pop         = commit_en && (count != '0);
  assign head_entry  = queue_mem[head];
  assign queue_count = count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        queue_mem[i] <= '0;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        queue_mem[tail] <= '{rd: wb_rd, data: wb_data};
        tail            <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Retirement: x0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regfile[i] <= '0;
      end
      commit_valid <= 1'b0;
      commit_rd    <= '0;
    end else begin
      commit_valid <= pop;
      if (pop) begin
        commit_rd <= head_entry.rd;
        if (head_entry.rd != 5'd0) begin
          regfile[head_entry.rd] <= head_entry.data;
        end
      end
    end
  end

  // Walk the queue oldest to youngest so the youngest matching entry wins.
  always_comb begin
    rs1_data = regfile[rs1_addr];
    rs2_data = regfile[rs2_addr];
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count) begin
        if (queue_mem[head + PW'(i)].rd == rs1_addr) begin
          rs1_data = queue_mem[head + PW'(i)].data;
        end
        if (queue_mem[head + PW'(i)].rd == rs2_addr) begin
          rs2_data = queue_mem[head + PW'(i)].data;
        end
      end
    end
    if (rs1_addr == 5'd0) begin
      rs1_data = '0;
    end
    if (rs2_addr == 5'd0) begin
      rs2_data = '0;
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed scenarios plus randomized traffic against a
// queue-based reference model of the pending writes and the register file.
module tb_writeback_unit;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            wb_valid;
  logic            wb_ready;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            commit_en;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            commit_valid;
  logic [4:0]      commit_rd;
  logic [1:0]      queue_count;

  int tests_run    = 0;
  int tests_failed = 0;

  writeback_unit #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(rst_n),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .commit_en(commit_en), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .queue_count(queue_count)
  );

  always #50 clk = ~clk;

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ent_t;

  ent_t            mq[$];
  logic [XLEN-1:0] mreg [32];
  logic            exp_cv;
  logic [4:0]      exp_crd;
  bit              last_push;

  function automatic logic [XLEN-1:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return '0;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].rd == a) return mq[i].data;
    end
    return mreg[a];
  endfunction

  task automatic m_reset();
    mq.delete();
    for (int i = 0; i < 32; i++) mreg[i] = '0;
    exp_cv  = 1'b0;
    exp_crd = '0;
  endtask

  // One rising edge: the model applies the pop and push decided from pre-edge state.
  task automatic tick();
    bit   do_push;
    bit   do_pop;
    ent_t e;
    ent_t n;
    do_push = wb_valid && (mq.size() < DEPTH);
    do_pop  = commit_en && (mq.size() > 0);
    n.rd    = wb_rd;
    n.data  = wb_data;
    @(posedge clk);
    if (do_pop) begin
      e = mq.pop_front();
      if (e.rd != 5'd0) mreg[e.rd] = e.data;
      exp_cv  = 1'b1;
      exp_crd = e.rd;
    end else begin
      exp_cv = 1'b0;
    end
    if (do_push) mq.push_back(n);
    last_push = do_push;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    commit_en = 1'b0; rs1_addr = 5'd7; rs2_addr = 5'd0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (queue_count !== 2'd0 || wb_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_queue count=%0d ready=%0b expected count=0 ready=1", queue_count, wb_ready);
    end
    tests_run++;
    if (commit_valid !== 1'b0 || commit_rd !== 5'd0) begin
      tests_failed++;
      $display("FAIL reset_commit cv=%0b crd=%0d expected 0/0", commit_valid, commit_rd);
    end
    tests_run++;
    if (rs1_data !== '0 || rs2_data !== '0) begin
      tests_failed++;
      $display("FAIL reset_read rs1=%h rs2=%h expected 0", rs1_data, rs2_data);
    end
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_basic();
    commit_en = 1'b1; wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hA5A5_0005; rs1_addr = 5'd5;
    #1;
    tests_run++;
    if (rs1_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL basic_not_visible rs1=%h expected 0", rs1_data);
    end
    tick();
    wb_valid = 1'b0;
    #1;
    tests_run++;
    if (rs1_data !== 32'hA5A5_0005 || queue_count !== 2'd1 || commit_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_queued rs1=%h cnt=%0d cv=%0b expected a5a50005/1/0", rs1_data, queue_count, commit_valid);
    end
    tick();
    tests_run++;
    if (commit_valid !== 1'b1 || commit_rd !== 5'd5 || rs1_data !== 32'hA5A5_0005) begin
      tests_failed++;
      $display("FAIL basic_retire cv=%0b crd=%0d rs1=%h expected 1/5/a5a50005", commit_valid, commit_rd, rs1_data);
    end
    tick();
    tests_run++;
    if (commit_valid !== 1'b0 || commit_rd !== 5'd5) begin
      tests_failed++;
      $display("FAIL basic_pulse cv=%0b crd=%0d expected 0/5", commit_valid, commit_rd);
    end
  endtask

  task automatic test_same_rd();
    commit_en = 1'b0; rs2_addr = 5'd3;
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h11; tick();
    wb_data = 32'h22; tick();
    tests_run++;
    if (queue_count !== 2'd2 || wb_ready !== 1'b0 || rs2_data !== 32'h22) begin
      tests_failed++;
      $display("FAIL same_rd_full cnt=%0d ready=%0b rs2=%h expected 2/0/22", queue_count, wb_ready, rs2_data);
    end
    wb_rd = 5'd7; wb_data = 32'h33; tick();
    tests_run++;
    if (queue_count !== 2'd2 || rs2_data !== 32'h22) begin
      tests_failed++;
      $display("FAIL same_rd_holdoff cnt=%0d rs2=%h expected 2/22", queue_count, rs2_data);
    end
    wb_valid = 1'b0; commit_en = 1'b1; tick();
    tests_run++;
    if (commit_valid !== 1'b1 || commit_rd !== 5'd3 || queue_count !== 2'd1) begin
      tests_failed++;
      $display("FAIL same_rd_first cv=%0b crd=%0d cnt=%0d expected 1/3/1", commit_valid, commit_rd, queue_count);
    end
    tick();
    tests_run++;
    if (commit_valid !== 1'b1 || queue_count !== 2'd0 || rs2_data !== 32'h22) begin
      tests_failed++;
      $display("FAIL same_rd_final cv=%0b cnt=%0d rs2=%h expected 1/0/22", commit_valid, queue_count, rs2_data);
    end
  endtask

  task automatic test_full_pop();
    commit_en = 1'b0; wb_valid = 1'b1;
    wb_rd = 5'd12; wb_data = 32'hC0C0_000C; tick();
    wb_rd = 5'd13; wb_data = 32'hD0D0_000D; tick();
    commit_en = 1'b1; wb_rd = 5'd14; wb_data = 32'hE0E0_000E;
    tick();
    tests_run++;
    if (queue_count !== 2'd1 || commit_rd !== 5'd12 || commit_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_pop_no_push cnt=%0d crd=%0d cv=%0b expected 1/12/1", queue_count, commit_rd, commit_valid);
    end
    tick();
    wb_valid = 1'b0; rs1_addr = 5'd14;
    #1;
    tests_run++;
    if (queue_count !== 2'd1 || commit_rd !== 5'd13 || rs1_data !== 32'hE0E0_000E) begin
      tests_failed++;
      $display("FAIL full_pop_accept cnt=%0d crd=%0d rs1=%h expected 1/13/e0e0000e", queue_count, commit_rd, rs1_data);
    end
    tick();
    tests_run++;
    if (queue_count !== 2'd0 || commit_rd !== 5'd14) begin
      tests_failed++;
      $display("FAIL full_pop_drain cnt=%0d crd=%0d expected 0/14", queue_count, commit_rd);
    end
  endtask

  task automatic test_x0();
    commit_en = 1'b1; wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF; rs1_addr = 5'd0;
    #1;
    tests_run++;
    if (rs1_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL x0_before rs1=%h expected 0", rs1_data);
    end
    tick();
    wb_valid = 1'b0;
    #1;
    tests_run++;
    if (rs1_data !== 32'h0 || queue_count !== 2'd1) begin
      tests_failed++;
      $display("FAIL x0_queued rs1=%h cnt=%0d expected 0/1", rs1_data, queue_count);
    end
    tick();
    tests_run++;
    if (commit_valid !== 1'b1 || commit_rd !== 5'd0 || rs1_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL x0_retire cv=%0b crd=%0d rs1=%h expected 1/0/0", commit_valid, commit_rd, rs1_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [XLEN-1:0] v;
    commit_en = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      wb_valid = 1'b1; wb_rd = 5'(k); wb_data = XLEN'(k) * 32'h0101;
      tick();
      tests_run++;
      if (queue_count !== 2'd1 || (k > 1 && (commit_valid !== 1'b1 || commit_rd !== 5'(k - 1)))) begin
        tests_failed++;
        $display("FAIL b2b_step%0d cnt=%0d cv=%0b crd=%0d expected 1/1/%0d", k, queue_count, commit_valid, commit_rd, k - 1);
      end
    end
    wb_valid = 1'b0;
    tick();
    for (int k = 1; k <= 10; k++) begin
      rs1_addr = 5'(k);
      v = XLEN'(k) * 32'h0101;
      #1;
      tests_run++;
      if (rs1_data !== v) begin
        tests_failed++;
        $display("FAIL b2b_reg%0d got=%h expected=%h", k, rs1_data, v);
      end
    end
  endtask

  task automatic test_random();
    logic [XLEN-1:0] e1;
    logic [XLEN-1:0] e2;
    last_push = 1'b0; wb_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!(wb_valid && !last_push)) begin
        wb_valid = ($urandom_range(0, 1) == 1);
        wb_rd    = 5'($urandom_range(0, 31));
        wb_data  = $urandom;
      end
      commit_en = ($urandom_range(0, 9) < 6);
      rs1_addr  = 5'($urandom_range(0, 31));
      rs2_addr  = ($urandom_range(0, 1) == 1) ? wb_rd : 5'($urandom_range(0, 31));
      #1;
      e1 = m_read(rs1_addr);
      e2 = m_read(rs2_addr);
      tests_run++;
      if (queue_count !== 2'(mq.size()) || wb_ready !== (mq.size() < DEPTH) ||
          rs1_data !== e1 || rs2_data !== e2 || commit_valid !== exp_cv ||
          (exp_cv && commit_rd !== exp_crd)) begin
        tests_failed++;
        $display("FAIL random_cyc%0d cnt=%0d/%0d rdy=%0b rs1=%h/%h rs2=%h/%h cv=%0b/%0b crd=%0d/%0d",
                 c, queue_count, mq.size(), wb_ready, rs1_data, e1, rs2_data, e2,
                 commit_valid, exp_cv, commit_rd, exp_crd);
      end
      tick();
    end
    wb_valid = 1'b0; commit_en = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    bit bad;
    commit_en = 1'b0; wb_valid = 1'b1;
    wb_rd = 5'd20; wb_data = 32'h2020_2020; tick();
    wb_rd = 5'd21; wb_data = 32'h2121_2121; tick();
    wb_valid = 1'b0; commit_en = 1'b1; rs1_addr = 5'd21;
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    tests_run++;
    if (queue_count !== 2'd0 || wb_ready !== 1'b1 || commit_valid !== 1'b0 || commit_rd !== 5'd0 || rs1_data !== '0) begin
      tests_failed++;
      $display("FAIL midreset_async cnt=%0d rdy=%0b cv=%0b crd=%0d rs1=%h expected 0/1/0/0/0",
               queue_count, wb_ready, commit_valid, commit_rd, rs1_data);
    end
    #2;
    rst_n = 1'b1;
    bad = 1'b0;
    for (int a = 0; a < 32; a++) begin
      rs1_addr = 5'(a); rs2_addr = 5'(31 - a);
      #1;
      if (rs1_data !== '0 || rs2_data !== '0) bad = 1'b1;
    end
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL midreset_regs some register nonzero after reset, expected all 0");
    end
    repeat (2) begin
      tick();
      tests_run++;
      if (commit_valid !== 1'b0 || queue_count !== 2'd0) begin
        tests_failed++;
        $display("FAIL midreset_no_commit cv=%0b cnt=%0d expected 0/0", commit_valid, queue_count);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_same_rd();
    test_full_pop();
    test_x0();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Parameters
REQ-001 XLEN, default 32, data width of each register and of the write-back data.
REQ-002 DEPTH, default 2, number of entries in the pending-write queue (power of two, at least 2).

Interface
REQ-003 clk  input  1  single clock; every state element is clocked on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 wb_valid  input  1  write-back request present.
REQ-006 wb_ready  output  1  queue can accept a request.
REQ-007 wb_rd  input  5  destination register index.
REQ-008 wb_data  input  XLEN  result to be written.
REQ-009 commit_en  input  1  high allows the queue to drain this cycle; low stalls the drain.
REQ-010 rs1_addr, rs2_addr  input  5 each  read-port register indices.
REQ-011 rs1_data, rs2_data  output  XLEN each  read-port results.
REQ-012 commit_valid  output  1  registered one-cycle pulse: an entry retired on the previous edge.
REQ-013 commit_rd  output  5  registered index of the retired entry.
REQ-014 queue_count  output  $clog2(DEPTH)+1  number of entries currently in the queue.

Function
REQ-015 Storage is a 32 x XLEN register file; register x0 is never written and always reads 0.
REQ-016 The queue is a circular FIFO with read and write pointers that wrap modulo DEPTH.
REQ-017 wb_ready = (queue_count != DEPTH); it is combinational from registered state only.
REQ-018 Push: on a rising edge with wb_valid && wb_ready, {wb_rd, wb_data} is written at the tail and the tail advances.
REQ-019 wb_valid while wb_ready is low is ignored; the source holds the request until it is accepted.
REQ-020 Pop: on a rising edge with commit_en && (queue_count != 0), the head entry retires, the head advances, and regfile[rd] <= data unless rd == 0.
REQ-021 Push and pop on the same edge are both performed; queue_count is unchanged. When full, a same-edge pop does NOT enable a push, because wb_ready is computed before the edge.
REQ-022 Latency: an entry accepted at edge N retires at edge N+1 at the earliest, when commit_en is high and no older entries remain.
REQ-023 commit_valid is 1 and commit_rd equals the retired rd for exactly the cycle after each pop; otherwise commit_valid is 0 and commit_rd holds its last value. An rd=0 entry pulses commit_valid with commit_rd=0 and writes nothing.
REQ-024 Reads are combinational. For address 0 the result is 0. Otherwise the result is the data of the youngest queue entry with a matching rd; if none matches, it is regfile[addr].
REQ-025 A request being pushed in the same cycle is not visible to the read ports until after the edge.
REQ-026 Two queued entries with the same rd retire in order, so the younger value is the one that remains in the register.

Reset
REQ-027 While reset is low: all 32 registers clear to 0, the pointers and queue_count clear to 0, commit_valid = 0, commit_rd = 0, and wb_ready = 1.
REQ-028 Reset asserted mid-operation discards every pending entry with no partial commit; normal operation resumes on the first rising edge after reset is released.

Verification
REQ-029 Reset, then push {rd=5, data=32'hA5A5_0005} with commit_en=1 -> commit_valid pulses one cycle later with commit_rd=5, and rs1_addr=5 reads 32'hA5A5_0005 both before and after retirement.
REQ-030 commit_en=0, push rd=3 value 32'h11 then rd=3 value 32'h22 -> queue_count=2, wb_ready=0, and rs2_addr=3 reads 32'h22. A third wb_valid is held off. With commit_en=1, the entries retire on two consecutive edges and the final register 3 value is 32'h22.
REQ-031 Queue full with commit_en=1 and wb_valid=1 in the same cycle -> the pop occurs, no push occurs, queue_count goes 2->1, and the held request is accepted on the next edge.
REQ-032 Push rd=0 with data 32'hFFFF_FFFF -> commit_valid=1 with commit_rd=0, and rs1_addr=0 reads 0 at all times.
REQ-033 Sustained back-to-back push and pop over 10 entries (rd=1..10, data=rd*16'h0101) -> queue_count stays at 1, the pointers wrap, and all ten registers hold their values afterwards.
REQ-034 Two entries pending, then reset pulsed low for 3 ns between clock edges -> queue_count=0, wb_ready=1, commit_valid=0 immediately, every register reads 0, and no commit_valid pulse follows.
